// File: rtl/mem_block_responder_pkg.sv
// Shared definitions for the main-memory block responder and its cache-side peers.
// Block layout: byte 0 is the most significant byte of the 256-bit word.
package mem_block_responder_pkg;

   localparam int BLOCK_W     = 256;
   localparam int OFFSET_BITS = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   // MSB position of byte k within a block; DCACHE uses the same mapping.
   function automatic int byte_msb(input int k);
      return BLOCK_W - 1 - 8 * k;
   endfunction

endpackage

// File: rtl/mem_block_array.sv
// Single-port synchronous block RAM with a registered read port.
// Contents are never cleared; only the read register is reset.
module mem_block_array
   import mem_block_responder_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               en,
   input  logic               we,
   input  logic [ADDR_W-1:0]  addr,
   input  logic [BLOCK_W-1:0] wdata,
   output logic [BLOCK_W-1:0] rdata
);

   logic [BLOCK_W-1:0] mem_r [2**ADDR_W];
   logic [BLOCK_W-1:0] rdata_r;

   // Storage write; a reset on the same edge suppresses the commit.
   always_ff @(posedge CLK) begin
      if (RESET && en && we) begin
         mem_r[addr] <= wdata;
      end
   end

   // Read register holds its value across writes and idle cycles.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         rdata_r <= {BLOCK_W{1'b0}};
      end else if (en && !we) begin
         rdata_r <= mem_r[addr];
      end else begin
         rdata_r <= rdata_r;
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/mem_block_responder.sv
// Serving end of the data cache's block miss/writeback protocol: one request at a
// time, fixed access latency, then a single-cycle response strobe.
module mem_block_responder
   import mem_block_responder_pkg::*;
#(
   parameter int LATENCY     = 10,
   parameter int BLOCKS_LOG2 = 10
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               req_valid,
   input  logic               req_write,
   input  logic [31:0]        req_addr,
   input  logic [BLOCK_W-1:0] req_wdata,
   output logic               req_ready,
   output logic [BLOCK_W-1:0] block_rdata,
   output logic               block_valid,
   output logic               resp_write
);

   localparam logic [7:0] COUNT_LOAD = 8'(LATENCY - 1);

   state_e                   state_r;
   logic [7:0]               count_r;
   logic [BLOCKS_LOG2-1:0]   index_r;
   logic                     write_r;
   logic [BLOCK_W-1:0]       wdata_r;
   logic                     req_ready_r;
   logic                     block_valid_r;
   logic                     resp_write_r;
   logic                     access_s;
   logic                     unused_s;

   // The array access happens on the last WAIT edge so the response lines up with RESP.
   assign access_s = (state_r == WAIT) && (count_r == 8'd0);
   assign unused_s = ^{req_addr[31:OFFSET_BITS+BLOCKS_LOG2], req_addr[OFFSET_BITS-1:0]};

   // Request/response sequencer with registered handshake outputs.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_r       <= IDLE;
         count_r       <= 8'd0;
         index_r       <= {BLOCKS_LOG2{1'b0}};
         write_r       <= 1'b0;
         wdata_r       <= {BLOCK_W{1'b0}};
         req_ready_r   <= 1'b1;
         block_valid_r <= 1'b0;
         resp_write_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (req_valid && req_ready_r) begin
                  index_r     <= req_addr[OFFSET_BITS+BLOCKS_LOG2-1:OFFSET_BITS];
                  write_r     <= req_write;
                  wdata_r     <= req_wdata;
                  count_r     <= COUNT_LOAD;
                  req_ready_r <= 1'b0;
                  state_r     <= WAIT;
               end else begin
                  req_ready_r <= 1'b1;
                  state_r     <= IDLE;
               end
            end
            WAIT: begin
               if (count_r != 8'd0) begin
                  count_r <= count_r - 8'd1;
               end else begin
                  block_valid_r <= 1'b1;
                  resp_write_r  <= write_r;
                  state_r       <= RESP;
               end
            end
            RESP: begin
               block_valid_r <= 1'b0;
               req_ready_r   <= 1'b1;
               state_r       <= IDLE;
            end
            default: begin
               block_valid_r <= 1'b0;
               req_ready_r   <= 1'b1;
               state_r       <= IDLE;
            end
         endcase
      end
   end

   mem_block_array #(
      .ADDR_W (BLOCKS_LOG2)
   ) u_array (
      .CLK   (CLK),
      .RESET (RESET),
      .en    (access_s),
      .we    (write_r),
      .addr  (index_r),
      .wdata (wdata_r),
      .rdata (block_rdata)
   );

   assign req_ready   = req_ready_r;
   assign block_valid = block_valid_r;
   assign resp_write  = resp_write_r;

endmodule

// File: tb/tb_mem_block_responder.sv
// Self-checking bench: directed scenarios plus random traffic against a block-level memory model,
// on a default-latency instance and a LATENCY=1 instance.
module tb_mem_block_responder;
   import mem_block_responder_pkg::*;

   localparam int LAT0   = 10;
   localparam int NBLK   = 1024;

   logic         CLK        = 1'b0;
   logic         RESET      = 1'b0;
   logic         req_valid  = 1'b0;
   logic         req_valid1 = 1'b0;
   logic         req_write  = 1'b0;
   logic [31:0]  req_addr   = 32'd0;
   logic [255:0] req_wdata  = 256'd0;
   logic         req_ready, req_ready1, block_valid, block_valid1, resp_write, resp_write1;
   logic [255:0] block_rdata, block_rdata1;

   int errors = 0;
   int checks = 0;
   logic [255:0] model0 [int];
   logic [255:0] model1 [int];
   logic [255:0] last_rd [2];

   always #5 CLK = ~CLK;

   mem_block_responder #(.LATENCY(LAT0), .BLOCKS_LOG2(10)) dut (
      .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .block_rdata(block_rdata), .block_valid(block_valid), .resp_write(resp_write));

   mem_block_responder #(.LATENCY(1), .BLOCKS_LOG2(10)) dut1 (
      .CLK(CLK), .RESET(RESET), .req_valid(req_valid1), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready1),
      .block_rdata(block_rdata1), .block_valid(block_valid1), .resp_write(resp_write1));

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int blk(input logic [31:0] a);
      return int'((a >> OFFSET_BITS) % NBLK);
   endfunction

   function automatic logic [255:0] rand_block();
      logic [255:0] d;
      for (int j = 0; j < 8; j++) d[32*j +: 32] = $urandom;
      return d;
   endfunction

   task automatic do_reset(input int cycles);
      RESET = 1'b0;
      repeat (cycles) @(posedge CLK);
      #1;
      RESET = 1'b1;
      last_rd[0] = 256'd0;
      last_rd[1] = 256'd0;
   endtask

   // Issue one request on instance sel (0: LATENCY=10, 1: LATENCY=1) and check the full response.
   task automatic do_req(input int sel, input bit wr, input logic [31:0] addr,
                         input logic [255:0] data, input string tag);
      int lat;
      bit seen;
      bit busy_ok;
      int explat;
      logic [255:0] exp_rd;
      explat = (sel == 1) ? 1 : LAT0;
      check({tag, ":ready_idle"}, (sel == 1) ? req_ready1 : req_ready, 1'b1);
      req_write = wr;
      req_addr  = addr;
      req_wdata = data;
      if (sel == 1) req_valid1 = 1'b1; else req_valid = 1'b1;
      @(posedge CLK); #1;
      req_valid  = 1'b0;
      req_valid1 = 1'b0;
      req_write  = 1'($urandom);
      req_addr   = $urandom;
      req_wdata  = rand_block();
      seen = 1'b0; lat = -1; busy_ok = 1'b1;
      for (int k = 0; k <= LAT0 + 5 && !seen; k++) begin
         if (((sel == 1) ? req_ready1 : req_ready) !== 1'b0) busy_ok = 1'b0;
         if (((sel == 1) ? block_valid1 : block_valid) === 1'b1) begin
            seen = 1'b1;
            lat  = k;
         end else begin
            @(posedge CLK); #1;
         end
      end
      check({tag, ":latency"}, lat, explat);
      check({tag, ":busy_not_ready"}, busy_ok, 1'b1);
      if (seen) begin
         if (wr) exp_rd = last_rd[sel];
         else    exp_rd = (sel == 1) ? model1[blk(addr)] : model0[blk(addr)];
         check({tag, ":resp_write"}, (sel == 1) ? resp_write1 : resp_write, wr);
         check({tag, ":rdata"}, (sel == 1) ? block_rdata1 : block_rdata, exp_rd);
         if (wr) begin
            if (sel == 1) model1[blk(addr)] = data; else model0[blk(addr)] = data;
         end else begin
            last_rd[sel] = exp_rd;
         end
         @(posedge CLK); #1;
         check({tag, ":valid_drop"}, (sel == 1) ? block_valid1 : block_valid, 1'b0);
         check({tag, ":ready_back"}, (sel == 1) ? req_ready1 : req_ready, 1'b1);
      end
   endtask

   initial begin
      logic [255:0] pat;
      logic [255:0] d;
      logic [31:0]  ad;
      bit           wr;
      bit           seen;

      for (int k = 0; k < 32; k++) pat[byte_msb(k) -: 8] = 8'((k % 16) * 17);

      // Reset and idle
      do_reset(2);
      check("rst:valid", block_valid, 1'b0);
      check("rst:rdata", block_rdata, 256'd0);
      check("rst:ready", req_ready, 1'b1);
      check("rst:resp_write", resp_write, 1'b0);
      check("rst:ready1", req_ready1, 1'b1);
      check("rst:valid1", block_valid1, 1'b0);

      // Write/read pair with the byte-pattern block
      do_req(0, 1'b1, 32'h0000_0040, pat, "wr40");
      do_req(0, 1'b0, 32'h0000_0047, 256'd0, "rd47");

      // Busy ignore: address/data wiggle during WAIT must not affect the response
      do_req(0, 1'b1, 32'h0000_0100, ~pat, "wr100");
      do_req(0, 1'b1, 32'h0000_0080, pat ^ {8{32'hA5A5_5A5A}}, "wr80");
      do_req(0, 1'b0, 32'h0000_0080, 256'd0, "rd80");

      // Aliasing modulo the array size
      do_req(0, 1'b1, 32'h0000_8000, rand_block(), "wr8000");
      do_req(0, 1'b0, 32'h0000_0000, 256'd0, "rd0000");

      // Reset in the middle of a write drops it
      do_req(0, 1'b1, 32'h0000_0200, rand_block(), "wr200");
      check("rstmid:ready_idle", req_ready, 1'b1);
      req_write = 1'b1; req_addr = 32'h0000_0200; req_wdata = rand_block(); req_valid = 1'b1;
      @(posedge CLK); #1;
      req_valid = 1'b0;
      repeat (4) begin @(posedge CLK); #1; end
      RESET = 1'b0;
      @(posedge CLK); #1;
      RESET = 1'b1;
      last_rd[0] = 256'd0;
      last_rd[1] = 256'd0;
      seen = 1'b0;
      for (int k = 0; k < LAT0 + 4; k++) begin
         if (block_valid !== 1'b0) seen = 1'b1;
         @(posedge CLK); #1;
      end
      check("rstmid:no_valid", seen, 1'b0);
      check("rstmid:ready", req_ready, 1'b1);
      check("rstmid:rdata", block_rdata, 256'd0);
      do_req(0, 1'b0, 32'h0000_0200, 256'd0, "rd200");

      // Random traffic over a small window of blocks with random alias bits
      for (int n = 0; n < 24; n++) begin
         ad = ($urandom & 32'hFFFF_8000) | (32'($urandom_range(0, 7)) << 5) | 32'($urandom_range(0, 31));
         wr = 1'($urandom_range(0, 1));
         if (!wr && !model0.exists(blk(ad))) wr = 1'b1;
         d = rand_block();
         do_req(0, wr, ad, d, "rand");
      end

      // LATENCY=1 instance
      do_req(1, 1'b1, 32'h0000_0060, pat, "l1_wr");
      do_req(1, 1'b0, 32'h0000_0060, 256'd0, "l1_rd");
      do_req(1, 1'b1, 32'h0000_0060, ~pat, "l1_wr2");
      do_req(1, 1'b0, 32'h0000_8060, 256'd0, "l1_rd_alias");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
